// File: rtl/tdoa_capture.sv
// tdoa_capture: arrival delays of mic2..4 relative to mic1 in prescaled ticks.
// Mic levels are synchronized and edge-detected; each result strobes out on ena.
module tdoa_capture #(
  parameter int TICK_DIV      = 5000,
  parameter int ENA_CYCLES    = 4,
  parameter int HOLDOFF_TICKS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] mic_hit,
  output logic [3:0] delay12,
  output logic [3:0] delay13,
  output logic [3:0] delay14,
  output logic       ena,
  output logic       busy,
  output logic       err_order,
  output logic       err_timeout
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int EW = $clog2(ENA_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_TICKS + 1);
  localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);
  localparam logic [EW-1:0] ECNT_MAX = EW'(ENA_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_MAX = HW'(HOLDOFF_TICKS - 1);

  // IDLE wait mic1 | CAPTURE latch ticks | DONE load outputs | STROBE ena | HOLDOFF echo mute
  typedef enum logic [2:0] {IDLE, CAPTURE, DONE, STROBE, HOLDOFF} state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, sync2_q, sync3_q;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [3:0]    tick_q, tick_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [EW-1:0] ecnt_q, ecnt_d;
  logic [3:1]    done_q, done_d;
  logic [3:0]    lat_q [3:1];
  logic [3:0]    lat_d [3:1];
  logic [3:0]    d12_q, d12_d, d13_q, d13_d, d14_q, d14_d;
  logic          ena_q, ena_d, busy_q, busy_d;
  logic          eord_q, eord_d, etmo_q, etmo_d;
  logic [3:0]    rise_w;
  logic          wrap_w;

  assign rise_w = sync2_q & ~sync3_q;
  assign wrap_w = (pcnt_q == PCNT_MAX);

  always_comb begin
    state_d = state_q;
    pcnt_d  = wrap_w ? '0 : pcnt_q + PW'(1);
    tick_d  = tick_q;
    hcnt_d  = hcnt_q;
    ecnt_d  = ecnt_q;
    done_d  = done_q;
    lat_d   = lat_q;
    d12_d   = d12_q;
    d13_d   = d13_q;
    d14_d   = d14_q;
    ena_d   = 1'b0;
    eord_d  = 1'b0;
    etmo_d  = 1'b0;
    busy_d  = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (rise_w[0]) begin
          // The mic1 edge cycle is count 0, so arrival c cycles later reads floor(c/TICK_DIV).
          state_d = CAPTURE;
          pcnt_d  = PW'(1);
          tick_d  = '0;
          done_d  = rise_w[3:1];
          for (int k = 1; k < 4; k++) lat_d[k] = '0;
        end else if (|rise_w[3:1]) begin
          eord_d  = 1'b1;
          state_d = HOLDOFF;
          pcnt_d  = '0;
          hcnt_d  = '0;
        end
      end
      CAPTURE: begin
        if (wrap_w) tick_d = tick_q + 4'd1;
        for (int k = 1; k < 4; k++) begin
          if (rise_w[k] && !done_q[k]) begin
            lat_d[k]  = tick_q;
            done_d[k] = 1'b1;
          end
        end
        if (&done_d) begin
          state_d = DONE;
        end else if (wrap_w && tick_q == 4'd15) begin
          etmo_d  = 1'b1;
          state_d = HOLDOFF;
          pcnt_d  = '0;
          hcnt_d  = '0;
        end
      end
      DONE: begin
        d12_d   = lat_q[1];
        d13_d   = lat_q[2];
        d14_d   = lat_q[3];
        ecnt_d  = '0;
        state_d = STROBE;
      end
      STROBE: begin
        ena_d = 1'b1;
        if (ecnt_q == ECNT_MAX) begin
          state_d = HOLDOFF;
          pcnt_d  = '0;
          hcnt_d  = '0;
        end else begin
          ecnt_d = ecnt_q + EW'(1);
        end
      end
      HOLDOFF: begin
        if (wrap_w) begin
          if (hcnt_q == HCNT_MAX) state_d = IDLE;
          else hcnt_d = hcnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      pcnt_q  <= '0;
      tick_q  <= '0;
      hcnt_q  <= '0;
      ecnt_q  <= '0;
      done_q  <= '0;
      for (int k = 1; k < 4; k++) lat_q[k] <= '0;
      d12_q   <= '0;
      d13_q   <= '0;
      d14_q   <= '0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      eord_q  <= 1'b0;
      etmo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= mic_hit;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      pcnt_q  <= pcnt_d;
      tick_q  <= tick_d;
      hcnt_q  <= hcnt_d;
      ecnt_q  <= ecnt_d;
      done_q  <= done_d;
      lat_q   <= lat_d;
      d12_q   <= d12_d;
      d13_q   <= d13_d;
      d14_q   <= d14_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
      eord_q  <= eord_d;
      etmo_q  <= etmo_d;
    end
  end

  assign delay12     = d12_q;
  assign delay13     = d13_q;
  assign delay14     = d14_q;
  assign ena         = ena_q;
  assign busy        = busy_q;
  assign err_order   = eord_q;
  assign err_timeout = etmo_q;

endmodule

// File: tb/tb_tdoa_capture.sv
// Directed bench for tdoa_capture with TICK_DIV=4, ENA_CYCLES=2, HOLDOFF_TICKS=3.
module tb_tdoa_capture;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mic_hit;
  logic [3:0] delay12, delay13, delay14;
  logic       ena, busy, err_order, err_timeout;
  int         n_tests = 0;
  int         n_fail  = 0;

  tdoa_capture #(.TICK_DIV(4), .ENA_CYCLES(2), .HOLDOFF_TICKS(3)) dut (
    .clk(clk), .rst(rst), .mic_hit(mic_hit),
    .delay12(delay12), .delay13(delay13), .delay14(delay14),
    .ena(ena), .busy(busy), .err_order(err_order), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_delays(input string tag, input logic [3:0] e12, input logic [3:0] e13,
                            input logic [3:0] e14);
    chk({tag, "_d12"}, {28'd0, delay12}, {28'd0, e12});
    chk({tag, "_d13"}, {28'd0, delay13}, {28'd0, e13});
    chk({tag, "_d14"}, {28'd0, delay14}, {28'd0, e14});
  endtask

  task automatic watch(input int n, output int n_ena, output int n_eo, output int n_et);
    n_ena = 0; n_eo = 0; n_et = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      n_ena += int'(ena);
      n_eo  += int'(err_order);
      n_et  += int'(err_timeout);
    end
  endtask

  task automatic wait_idle(input string tag, input int max);
    for (int i = 0; i < max && busy !== 1'b0; i++) step(1);
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic nominal(input string tag);
    mic_hit = 4'b0001;
    step(9);  mic_hit = 4'b0011;
    step(4);  mic_hit = 4'b1011;
    step(9);  mic_hit = 4'b1111;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (i == 3) chk({tag, "_d12_early"}, {28'd0, delay12}, 32'd0);
      if (i == 4) chk_delays(tag, 4'd2, 4'd5, 4'd3);
      if (i <= 8) chk({tag, "_ena"}, {31'd0, ena}, {31'd0, (i == 5 || i == 6)});
      if (i == 18) chk({tag, "_busy18"}, {31'd0, busy}, 32'd1);
      if (i == 19) chk({tag, "_busy19"}, {31'd0, busy}, 32'd0);
    end
    mic_hit = 4'b0000;
    step(4);
  endtask

  initial begin
    int n_ena, n_eo, n_et, et_at;
    rst = 1'b1;
    mic_hit = 4'b0000;
    step(3);
    rst = 1'b0;
    chk_delays("reset", 4'd0, 4'd0, 4'd0);
    chk("reset_ena", {31'd0, ena}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_errs", {30'd0, err_order, err_timeout}, 32'd0);
    step(2);

    nominal("nom1");

    // mic3 two cycles ahead of mic1
    mic_hit = 4'b0100;
    step(2);  mic_hit = 4'b0101;
    step(1);  chk("order_pulse", {31'd0, err_order}, 32'd1);
    step(1);  chk("order_single", {31'd0, err_order}, 32'd0);
    watch(8, n_ena, n_eo, n_et);
    chk("order_no_ena", n_ena, 32'd0);
    chk("order_no_extra", n_eo + n_et, 32'd0);
    wait_idle("order_idle", 20);
    chk_delays("order_keep", 4'd2, 4'd5, 4'd3);
    mic_hit = 4'b0000;
    step(3);

    // mic3 never arrives
    mic_hit = 4'b0001;
    n_ena = 0; n_et = 0; et_at = -1;
    for (int i = 1; i <= 70; i++) begin
      step(1);
      if (i == 3) mic_hit = 4'b0011;
      if (i == 6) mic_hit = 4'b1011;
      n_ena += int'(ena);
      if (err_timeout) begin
        n_et++;
        et_at = i;
      end
    end
    chk("tmo_count", n_et, 32'd1);
    chk("tmo_when", et_at, 32'd66);
    chk("tmo_no_ena", n_ena, 32'd0);
    chk_delays("tmo_keep", 4'd2, 4'd5, 4'd3);
    wait_idle("tmo_idle", 20);
    mic_hit = 4'b0000;
    step(3);

    mic_hit = 4'b1111;
    watch(10, n_ena, n_eo, n_et);
    chk("sim_ena", n_ena, 32'd2);
    chk("sim_no_err", n_eo + n_et, 32'd0);
    chk_delays("sim", 4'd0, 4'd0, 4'd0);
    wait_idle("sim_idle", 20);
    mic_hit = 4'b0000;
    step(3);

    // floor boundaries at c=4, c=8 and the last accepted arrival c=63
    mic_hit = 4'b0001;
    n_ena = 0; n_et = 0;
    for (int i = 1; i <= 75; i++) begin
      step(1);
      if (i == 4)  mic_hit = 4'b0011;
      if (i == 8)  mic_hit = 4'b0111;
      if (i == 63) mic_hit = 4'b1111;
      n_ena += int'(ena);
      n_et  += int'(err_timeout);
    end
    chk("edge63_ena", n_ena, 32'd2);
    chk("edge63_no_tmo", n_et, 32'd0);
    chk_delays("edge63", 4'd1, 4'd2, 4'd15);

    // echo edges while still muted
    chk("echo_in_holdoff", {31'd0, busy}, 32'd1);
    mic_hit = 4'b0000;
    step(1);  mic_hit = 4'b0011;
    watch(30, n_ena, n_eo, n_et);
    chk("echo_ignored", n_ena + n_eo + n_et, 32'd0);
    chk("echo_idle", {31'd0, busy}, 32'd0);

    // mic1 stuck high, fresh mic2 edge
    mic_hit = 4'b0001;
    step(3);  mic_hit = 4'b0011;
    watch(6, n_ena, n_eo, n_et);
    chk("stuck_order", n_eo, 32'd1);
    chk("stuck_no_ena", n_ena, 32'd0);
    wait_idle("stuck_idle", 20);
    mic_hit = 4'b0000;
    step(3);

    mic_hit = 4'b0001;
    step(3);  mic_hit = 4'b0011;
    step(4);
    rst = 1'b1;
    mic_hit = 4'b0000;
    step(1);
    chk_delays("rst_mid", 4'd0, 4'd0, 4'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_ena", {31'd0, ena}, 32'd0);
    chk("rst_mid_errs", {30'd0, err_order, err_timeout}, 32'd0);
    rst = 1'b0;
    step(2);
    nominal("nom2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tdoa_capture.md
# tdoa_capture

Front-end timing block that measures the arrival delays of an acoustic event at microphones 2, 3 and 4 relative to microphone 1, in 0.1 ms units. It turns four comparator-level `mic_hit` inputs into `delay12`/`delay13`/`delay14` plus an `ena` strobe. These outputs drive the position calculator's delay and start inputs directly. Microphone 1 is the array reference and must hear the event first.

## Interface

- `TICK_DIV`, 5000: clk cycles per 0.1 ms delay unit (50 MHz clk); ≥2
- `ENA_CYCLES`, 4: cycles `ena` is held high per result; ≥1
- `HOLDOFF_TICKS`, 1000: delay units of echo suppression after any result or error; ≥1
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `mic_hit`  in  4  async threshold-crossing levels; bit0 = mic1 … bit3 = mic4
- `delay12`  out  4  mic2 arrival minus mic1 arrival, units of 0.1 ms
- `delay13`  out  4  mic3 arrival minus mic1 arrival
- `delay14`  out  4  mic4 arrival minus mic1 arrival
- `ena`  out  1  result strobe; rises only when delays are already stable
- `busy`  out  1  high in every state except IDLE
- `err_order`  out  1  one-cycle pulse; another mic fired before mic1
- `err_timeout`  out  1  one-cycle pulse; event incomplete within 15 units

## Operation

- Each `mic_hit` bit passes through a 2-flop synchronizer, then a rising-edge detector (`s2 & ~s3`). Only rising edges count, so a stuck-high input never triggers.
- Prescaler `pcnt` (0..TICK_DIV-1) and 4-bit `tick` count elapsed units. A capture step occurs when `pcnt` wraps: `tick` increments, and in HOLDOFF so does `hcnt`.
- State machine:
  - IDLE
    - Edges on mic1 only, or mic1 together with any others in the same cycle: go to CAPTURE. Clear `pcnt` and `tick`; latch a delay of 0 for every mic edged in that cycle and mark it done.
    - Edge on any of mic2..4 without mic1: pulse `err_order`, go to HOLDOFF.
  - CAPTURE
    - First edge on mic k (k=2..4) latches `tick` as that delay and marks k done.
    - Repeat edges and mic1 edges are ignored.
    - When all three are done, including the completing cycle, go to DONE.
    - If `tick`=15 and `pcnt` wraps with any mic not done, pulse `err_timeout` and go to HOLDOFF.
    - The completion check takes priority over timeout in the same cycle.
  - DONE: copy the three latched delays into the output registers, go to STROBE.
  - STROBE: `ena`=1 for ENA_CYCLES cycles, then go to HOLDOFF.
  - HOLDOFF: clear `hcnt` on entry; ignore all edges; after HOLDOFF_TICKS units go to IDLE.
- Arrival c cycles after the mic1 edge gives delay = floor(c/TICK_DIV), valid for c < 16·TICK_DIV.
- Output delay registers change only in DONE. They hold their value across errors and later events until the next DONE.
- `rst` mid-operation: the next state is IDLE. Every output and internal counter takes its reset value on the following cycle, and synchronizer flops clear to 0.

## Timing

- Reset values: `delay12`=`delay13`=`delay14`=0, `ena`=0, `busy`=0, `err_order`=0, `err_timeout`=0.
- Synchronizer plus edge-detect latency is 3 clk. It is identical on all channels, so delays are unaffected.
- The last needed raw rise is sampled at clk edge k:
  - CAPTURE completes at edge k+2.
  - Delay outputs are valid after edge k+3 (DONE).
  - `ena` rises after edge k+4, so delays are stable ≥1 cycle before `ena`.
- `ena` is high exactly ENA_CYCLES cycles. It is never re-asserted until the state machine passes through IDLE again.
- Error pulses are exactly one cycle, registered, and asserted the cycle after the offending edge or wrap is seen.
- Minimum spacing between results is ENA_CYCLES + HOLDOFF_TICKS·TICK_DIV cycles.

## Test plan

Benches use TICK_DIV=4, ENA_CYCLES=2, HOLDOFF_TICKS=3.

- Nominal event: mic1 rises at t0; mic2 at t0+9, mic4 at t0+13, mic3 at t0+22 clk.
  - Required: `delay12`=2, `delay14`=3, `delay13`=5.
  - `ena` high 2 cycles, starting exactly 5 clk after mic3's rise.
  - `busy` returns low 12 clk after `ena` falls.
- Simultaneous arrival: all four bits rise in the same cycle.
  - Required: delays 0/0/0, `ena` pulse, no error.
- Wrong order: mic3 rises 2 clk before mic1.
  - Required: one `err_order` pulse, no `ena`, delays retain their previous values, then back to IDLE.
- Timeout: mic1, mic2 and mic4 fire; mic3 never does.
  - Required: `err_timeout` one pulse 64 clk after mic1's edge is seen, no `ena`, outputs unchanged.
- Boundary and echo:
  - An arrival at c=63 gives delay 15 and the event is accepted.
  - Edges during HOLDOFF are ignored.
  - A stuck-high mic1 with new mic2 edges after HOLDOFF produces `err_order`.
- Reset mid-CAPTURE after mic1 and mic2.
  - Required: all outputs read 0 the next cycle, `busy`=0.
  - A fresh nominal event afterwards measures correctly.
